// File: rtl/joybus_rx.sv
// Joybus receive stage: decodes controller response bit cells into bytes after the
// transmitter arms it, then reports completion, framing errors and no-response timeouts.
module joybus_rx #(
    parameter int SAMPLE_CYC       = 48,
    parameter int END_CYC          = 96,
    parameter int LOW_MAX_CYC      = 96,
    parameter int RESP_TIMEOUT_CYC = 2400,
    parameter int MAX_BYTES        = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       JB_RX,
    input  logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_byte_vld,
    output logic [5:0] rx_byte_cnt,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_timeout
);

    localparam int CNT_W = $clog2(RESP_TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        BIT_LOW,
        WAIT_HIGH,
        GAP,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             jb_meta, jb_sync, jb_prev;
    logic             tx_done_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt;

    logic fe, arm;
    logic sample, byte_done, set_err, set_to;

    assign fe      = jb_prev & ~jb_sync;
    assign arm     = tx_done & ~tx_done_q;
    assign rx_done = (state == DONE);

    // Line is idle high, so the synchronizer resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jb_meta   <= 1'b1;
            jb_sync   <= 1'b1;
            jb_prev   <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            jb_meta   <= JB_RX;
            jb_sync   <= jb_meta;
            jb_prev   <= jb_sync;
            tx_done_q <= tx_done;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        byte_done = 1'b0;
        set_err   = 1'b0;
        set_to    = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (fe) begin
                    state_nxt = BIT_LOW;
                end else if (cnt == CNT_W'(RESP_TIMEOUT_CYC - 1)) begin
                    state_nxt = DONE;
                    set_to    = 1'b1;
                end
            end
            BIT_LOW: begin
                if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                    if (bit_cnt == 3'd7 && rx_byte_cnt == 6'(MAX_BYTES)) begin
                        state_nxt = DONE;
                        set_err   = 1'b1;
                    end else begin
                        sample    = 1'b1;
                        byte_done = (bit_cnt == 3'd7);
                        state_nxt = jb_sync ? GAP : WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // WAIT_HIGH starts SAMPLE_CYC+1 cycles after the edge; this bounds total low time.
                if (jb_sync) begin
                    state_nxt = GAP;
                end else if (cnt == CNT_W'(LOW_MAX_CYC - SAMPLE_CYC)) begin
                    state_nxt = DONE;
                    set_err   = 1'b1;
                end
            end
            GAP: begin
                if (fe) begin
                    state_nxt = BIT_LOW;
                end else if (cnt == CNT_W'(END_CYC - 1)) begin
                    state_nxt = DONE;
                    // A good frame ends with exactly the stop bit beyond whole bytes.
                    set_err   = (bit_cnt != 3'd1) || (rx_byte_cnt == 6'd0);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_byte_vld <= 1'b0;
            rx_byte_cnt <= '0;
            rx_err      <= 1'b0;
            rx_timeout  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_byte_vld <= byte_done;

            if (state_nxt != state || state == IDLE) cnt <= '0;
            else                                     cnt <= cnt + CNT_W'(1);

            if (state == IDLE && arm) begin
                rx_err      <= 1'b0;
                rx_timeout  <= 1'b0;
                rx_byte_cnt <= '0;
                bit_cnt     <= '0;
            end

            if (sample) begin
                shift_q <= {shift_q[6:0], jb_sync};
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                rx_data     <= {shift_q[6:0], jb_sync};
                rx_byte_cnt <= rx_byte_cnt + 6'd1;
            end

            if (set_err) rx_err     <= 1'b1;
            if (set_to)  rx_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_joybus_rx.sv
// Directed bench for joybus_rx: controller-style bit cells are driven onto the line
// and byte strobes, frame results and timing are compared against hand-derived values.
module tb_joybus_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       JB_RX = 1'b1;
    logic       tx_done = 1'b0;
    logic [7:0] rx_data;
    logic       rx_byte_vld;
    logic [5:0] rx_byte_cnt;
    logic       rx_done;
    logic       rx_err;
    logic       rx_timeout;

    always #5 clk = ~clk;

    joybus_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .JB_RX       (JB_RX),
        .tx_done     (tx_done),
        .rx_data     (rx_data),
        .rx_byte_vld (rx_byte_vld),
        .rx_byte_cnt (rx_byte_cnt),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .rx_timeout  (rx_timeout)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] vld_q[$];
    int         done_cnt = 0;
    logic       err_at_done;
    logic       to_at_done;
    logic [5:0] cnt_at_done;

    // Passive monitor: records every strobed byte and the flags seen with each rx_done.
    always @(negedge clk) begin
        if (rx_byte_vld) vld_q.push_back(rx_data);
        if (rx_done) begin
            done_cnt    <= done_cnt + 1;
            err_at_done <= rx_err;
            to_at_done  <= rx_timeout;
            cnt_at_done <= rx_byte_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        JB_RX = 1'b0;
        repeat (b ? 24 : 72) @(negedge clk);
        JB_RX = 1'b1;
        repeat (b ? 72 : 24) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        JB_RX = 1'b0;
        repeat (48) @(negedge clk);
        JB_RX = 1'b1;
    endtask

    task automatic arm();
        @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) begin
            @(negedge clk);
            #1;
        end
        chk(tag, done_cnt, start + 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_flags", {rx_byte_vld, rx_done, rx_err, rx_timeout}, 4'b0000);
        chk("rst_cnt", rx_byte_cnt, 6'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Line traffic while unarmed is ignored
        send_byte(8'h55);
        send_stop();
        repeat (150) @(negedge clk);
        chk("idle_no_vld", vld_q.size(), 0);
        chk("idle_no_done", done_cnt, 0);

        // Good 3-byte response
        vld_q.delete();
        arm();
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h02);
        send_stop();
        wait_done("good_done", 400);
        chk("good_nbytes", vld_q.size(), 3);
        if (vld_q.size() == 3) begin
            chk("good_b0", vld_q[0], 8'h05);
            chk("good_b1", vld_q[1], 8'h00);
            chk("good_b2", vld_q[2], 8'h02);
        end
        chk("good_cnt", cnt_at_done, 6'd3);
        chk("good_err", err_at_done, 1'b0);
        chk("good_to", to_at_done, 1'b0);
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        chk("good_single_done", done_cnt, d0);

        // No response: timeout exactly 2400 cycles after the arming edge
        vld_q.delete();
        @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(posedge clk);
        n = 0;
        while (!rx_done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("to_latency", n, 2400);
        chk("to_flag", rx_timeout, 1'b1);
        chk("to_err", rx_err, 1'b0);
        chk("to_cnt", rx_byte_cnt, 6'd0);
        repeat (3) @(negedge clk);
        chk("to_no_vld", vld_q.size(), 0);
        chk("to_flag_held", rx_timeout, 1'b1);

        // One byte followed by three stray bit cells and no stop
        vld_q.delete();
        arm();
        chk("rearm_clears_to", rx_timeout, 1'b0);
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_done("frag_done", 400);
        chk("frag_nbytes", vld_q.size(), 1);
        if (vld_q.size() == 1) chk("frag_b0", vld_q[0], 8'hA5);
        chk("frag_err", err_at_done, 1'b1);

        // Stuck-low line: error roughly LOW_MAX_CYC after the fall
        arm();
        chk("rearm_clears_err", rx_err, 1'b0);
        JB_RX = 1'b0;
        n = 0;
        while (!rx_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_in_window", (n >= 96 && n <= 104), 1'b1);
        chk("stuck_err", rx_err, 1'b1);
        JB_RX = 1'b1;
        repeat (20) @(negedge clk);

        // Overflow: 34 bytes, the last one is rejected
        vld_q.delete();
        d0 = done_cnt;
        arm();
        for (int b = 0; b < 34; b++) send_byte(8'(b + 8'h40));
        send_stop();
        repeat (200) @(negedge clk);
        chk("ovf_done_once", done_cnt, d0 + 1);
        chk("ovf_nbytes", vld_q.size(), 33);
        if (vld_q.size() == 33) begin
            chk("ovf_first", vld_q[0], 8'h40);
            chk("ovf_last", vld_q[32], 8'h60);
        end
        chk("ovf_err", err_at_done, 1'b1);
        chk("ovf_cnt", cnt_at_done, 6'd33);
        chk("ovf_cnt_held", rx_byte_cnt, 6'd33);

        // Reset during the second byte, then a clean frame
        vld_q.delete();
        arm();
        send_byte(8'h12);
        send_bit(1'b0);
        send_bit(1'b1);
        JB_RX = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_byte1", rx_data, 8'h12);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_cnt", rx_byte_cnt, 6'd0);
        chk("mid_rst_flags", {rx_byte_vld, rx_done, rx_err, rx_timeout}, 4'b0000);
        repeat (3) @(negedge clk);
        JB_RX = 1'b1;
        tx_done = 1'b0;
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("mid_no_done", done_cnt, d0);

        vld_q.delete();
        arm();
        send_byte(8'hFF);
        send_stop();
        wait_done("ff_done", 400);
        chk("ff_nbytes", vld_q.size(), 1);
        if (vld_q.size() == 1) chk("ff_b0", vld_q[0], 8'hFF);
        chk("ff_err", err_at_done, 1'b0);
        chk("ff_cnt", cnt_at_done, 6'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
